// File: rtl/dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_pkg
// Brief    : Shared error-class and status encodings for the decoder datapath.
// Revision : 1.0
// ============================================================================
package dec_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SINGLE = 2'b01,
        ERR_DOUBLE = 2'b10,
        ERR_RSVD   = 2'b11
    } err_kind_t;

    typedef enum logic [1:0] {
        ST_CLEAN     = 2'b00,
        ST_CORRECTED = 2'b01,
        ST_UNCORR    = 2'b10
    } dec_status_t;

endpackage
`default_nettype wire

// File: rtl/dec_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : dec_sat_counter
// Brief    : Saturating event counter; clear wins over a same-cycle increment.
// Revision : 1.0
// ============================================================================
module dec_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/dec_correct_stage.sv
`default_nettype none
// ============================================================================
// Module   : dec_correct_stage
// Brief    : Registered valid/ready single-bit correction stage with stats.
// Revision : 1.0
// ============================================================================
module dec_correct_stage
    import dec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int POS_W      = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] codeword,
    input  logic [POS_W-1:0]      err_pos,
    input  logic [1:0]            err_kind,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            out_status,
    output logic [CNT_W-1:0]      corr_cnt,
    output logic [CNT_W-1:0]      uncorr_cnt,
    input  logic                  cnt_clr
);

    // One extra bit so DATA_WIDTH == 2**POS_W still compares correctly.
    localparam logic [POS_W:0]        C_DATA_WIDTH = (POS_W+1)'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] C_BIT0       = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    err_kind_t             w_kind;
    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_flip_mask;
    logic                  w_accept;
    logic                  w_inc_corr;
    logic                  w_inc_uncorr;

    logic                  valid_q;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    dec_status_t           status_q;
    dec_status_t           status_d;

    assign w_kind      = err_kind_t'(err_kind);
    assign w_in_range  = ({1'b0, err_pos} < C_DATA_WIDTH);
    assign w_flip_mask = w_in_range ? (C_BIT0 << err_pos) : '0;

    assign in_ready = !valid_q || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        data_d   = codeword;
        status_d = ST_CLEAN;
        case (w_kind)
            ERR_NONE: begin
                status_d = ST_CLEAN;
            end
            ERR_SINGLE: begin
                if (w_in_range) begin
                    data_d   = codeword ^ w_flip_mask;
                    status_d = ST_CORRECTED;
                end else begin
                    status_d = ST_UNCORR;
                end
            end
            default: begin
                status_d = ST_UNCORR;
            end
        endcase
    end

    // A retiring beat is replaced in place when a new one is accepted.
    assign valid_d = w_accept || (valid_q && !out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            status_q <= ST_CLEAN;
        end else begin
            valid_q <= valid_d;
            if (w_accept) begin
                data_q   <= data_d;
                status_q <= status_d;
            end
        end
    end

    assign out_valid  = valid_q;
    assign data_out   = data_q;
    assign out_status = status_q;

    // Counting at accept keeps statistics independent of downstream stalls.
    assign w_inc_corr   = w_accept && (status_d == ST_CORRECTED);
    assign w_inc_uncorr = w_accept && (status_d == ST_UNCORR);

    dec_sat_counter #(
        .CNT_W (CNT_W)
    ) u_corr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_inc_corr),
        .clr (cnt_clr),
        .cnt (corr_cnt)
    );

    dec_sat_counter #(
        .CNT_W (CNT_W)
    ) u_uncorr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_inc_uncorr),
        .clr (cnt_clr),
        .cnt (uncorr_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_dec_correct_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_correct_stage
// Brief    : Bench for dec_correct_stage at widths 32/16/8 sharing one stimulus.
// Revision : 1.0
// ============================================================================
module tb_dec_correct_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic [31:0] codeword = '0;
    logic [4:0]  err_pos = '0;
    logic [1:0]  err_kind = '0;

    logic        rdy_a, rdy_b, rdy_c;
    logic        vld_a, vld_b, vld_c;
    logic [31:0] dat_a;
    logic [15:0] dat_b;
    logic [7:0]  dat_c;
    logic [1:0]  stat_a, stat_b, stat_c;
    logic [15:0] corr_a, uncorr_a, corr_c, uncorr_c;
    logic [1:0]  corr_b, uncorr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_correct_stage #(.DATA_WIDTH(32), .POS_W(5), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .codeword(codeword), .err_pos(err_pos), .err_kind(err_kind),
        .out_valid(vld_a), .out_ready(out_ready), .data_out(dat_a),
        .out_status(stat_a), .corr_cnt(corr_a), .uncorr_cnt(uncorr_a), .cnt_clr(cnt_clr)
    );

    dec_correct_stage #(.DATA_WIDTH(16), .POS_W(5), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .codeword(codeword[15:0]), .err_pos(err_pos), .err_kind(err_kind),
        .out_valid(vld_b), .out_ready(out_ready), .data_out(dat_b),
        .out_status(stat_b), .corr_cnt(corr_b), .uncorr_cnt(uncorr_b), .cnt_clr(cnt_clr)
    );

    dec_correct_stage #(.DATA_WIDTH(8), .POS_W(5), .CNT_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
        .codeword(codeword[7:0]), .err_pos(err_pos), .err_kind(err_kind),
        .out_valid(vld_c), .out_ready(out_ready), .data_out(dat_c),
        .out_status(stat_c), .corr_cnt(corr_c), .uncorr_cnt(uncorr_c), .cnt_clr(cnt_clr)
    );

    // Reference: truncate to width, then add or subtract 2**pos to toggle that bit.
    function automatic void ref_beat(input int w, input logic [31:0] cw, input int pos,
                                     input int kind, output logic [31:0] d, output int st);
        longint full;
        longint pw;
        full = longint'(cw) % (64'd1 << w);
        st   = 0;
        if (kind == 1 && pos < w) begin
            pw   = 64'd1 << pos;
            full = (((full / pw) % 2) == 1) ? full - pw : full + pw;
            st   = 1;
        end else if (kind != 0) begin
            st = 2;
        end
        d = full[31:0];
    endfunction

    task automatic drive(input logic v, input logic [31:0] cw, input int pos, input int kind);
        in_valid = v;
        codeword = cw;
        err_pos  = pos[4:0];
        err_kind = kind[1:0];
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 0, 0);
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 32'h0, 0, 0);
        #2;
        checks++;
        if ({vld_a, dat_a, stat_a, corr_a, uncorr_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: valid=%b data=%h status=%b corr=%0d uncorr=%0d, required all zero",
                     vld_a, dat_a, stat_a, corr_a, uncorr_a);
        end
        checks++;
        if ({vld_b, dat_b, stat_b, corr_b, uncorr_b, vld_c, dat_c, stat_c, corr_c, uncorr_c} !== '0) begin
            errors++;
            $display("FAIL reset_bc: b valid=%b data=%h c valid=%b data=%h, required all zero",
                     vld_b, dat_b, vld_c, dat_c);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, required 111", {rdy_a, rdy_b, rdy_c});
        end
    endtask

    task automatic test_single_bit();
        do_reset();
        drive(1'b1, 32'h0, 5, 1);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 0, 0);
        checks++;
        if ({vld_a, dat_a, stat_a, corr_a, uncorr_a} !== {1'b1, 32'h0000_0020, 2'b01, 16'd1, 16'd0}) begin
            errors++;
            $display("FAIL single_bit: valid=%b data=%h status=%b corr=%0d uncorr=%0d, required 1 00000020 01 1 0",
                     vld_a, dat_a, stat_a, corr_a, uncorr_a);
        end
        checks++;
        if ({dat_c, stat_c} !== {8'h20, 2'b01}) begin
            errors++;
            $display("FAIL single_bit_w8: data=%h status=%b, required 20 01", dat_c, stat_c);
        end
        @(posedge clk);
        #1;
        checks++;
        if (vld_a !== 1'b0) begin
            errors++;
            $display("FAIL retire: out_valid=%b, required 0", vld_a);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        drive(1'b1, 32'h0000_BEEF, 20, 1);
        @(posedge clk);
        #1;
        checks++;
        if ({dat_b, stat_b, uncorr_b, corr_b} !== {16'hBEEF, 2'b10, 2'd1, 2'd0}) begin
            errors++;
            $display("FAIL oor_pos20_w16: data=%h status=%b uncorr=%0d corr=%0d, required BEEF 10 1 0",
                     dat_b, stat_b, uncorr_b, corr_b);
        end
        checks++;
        if ({dat_a, stat_a} !== {32'h0010_BEEF, 2'b01}) begin
            errors++;
            $display("FAIL inrange_pos20_w32: data=%h status=%b, required 0010BEEF 01", dat_a, stat_a);
        end
        drive(1'b1, 32'h0000_BEEF, 16, 1);
        @(posedge clk);
        #1;
        checks++;
        if ({dat_b, stat_b, uncorr_b} !== {16'hBEEF, 2'b10, 2'd2}) begin
            errors++;
            $display("FAIL oor_pos16_w16: data=%h status=%b uncorr=%0d, required BEEF 10 2",
                     dat_b, stat_b, uncorr_b);
        end
        drive(1'b1, 32'h0000_BEEF, 15, 1);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 0, 0);
        checks++;
        if ({dat_b, stat_b, corr_b} !== {16'h3EEF, 2'b01, 2'd1}) begin
            errors++;
            $display("FAIL edge_pos15_w16: data=%h status=%b corr=%0d, required 3EEF 01 1",
                     dat_b, stat_b, corr_b);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 32'h0000_1234, 0, 0);
        @(posedge clk);
        #1;
        drive(1'b1, 32'h0000_5678, 3, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rdy_a !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready cycle %0d: in_ready=%b, required 0", i, rdy_a);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({vld_a, dat_a, stat_a} !== {1'b1, 32'h0000_1234, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b data=%h status=%b, required 1 00001234 00",
                         i, vld_a, dat_a, stat_a);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b, required 1", rdy_a);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 0, 0);
        checks++;
        if ({vld_a, dat_a, stat_a, corr_a} !== {1'b1, 32'h0000_5670, 2'b01, 16'd1}) begin
            errors++;
            $display("FAIL bp_swap: valid=%b data=%h status=%b corr=%0d, required 1 00005670 01 1",
                     vld_a, dat_a, stat_a, corr_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (vld_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b, required 0", vld_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h0, i, 1);
            @(posedge clk);
            #1;
            checks++;
            if ({vld_c, dat_c, stat_c} !== {1'b1, exp_tbl[i], 2'b01}) begin
                errors++;
                $display("FAIL stream beat %0d: valid=%b data=%h status=%b, required 1 %h 01",
                         i, vld_c, dat_c, stat_c, exp_tbl[i]);
            end
        end
        drive(1'b0, 32'h0, 0, 0);
        checks++;
        if (corr_c !== 16'd8) begin
            errors++;
            $display("FAIL stream_count: corr_cnt=%0d, required 8", corr_c);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_tbl [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, int'($urandom_range(0, 31)), 2);
            @(posedge clk);
            #1;
            checks++;
            if (uncorr_b !== exp_tbl[i]) begin
                errors++;
                $display("FAIL saturate beat %0d: uncorr_cnt=%0d, required %0d", i, uncorr_b, exp_tbl[i]);
            end
        end
        checks++;
        if (uncorr_a !== 16'd5) begin
            errors++;
            $display("FAIL count_wide: uncorr_cnt=%0d, required 5", uncorr_a);
        end
        drive(1'b1, $urandom, 0, 3);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        drive(1'b0, 32'h0, 0, 0);
        checks++;
        if ({uncorr_b, uncorr_a} !== {2'd0, 16'd0}) begin
            errors++;
            $display("FAIL clr_priority: uncorr_b=%0d uncorr_a=%0d, required 0 0", uncorr_b, uncorr_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 32'h0000_AAAA, 1, 1);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 0, 0);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({vld_a, corr_a} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL pre_reset: valid=%b corr=%0d, required 1 1", vld_a, corr_a);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({vld_a, corr_a, vld_b, corr_b, vld_c, corr_c} !== '0) begin
            errors++;
            $display("FAIL async_reset: valid a/b/c=%b%b%b corr_a=%0d, required 000 0",
                     vld_a, vld_b, vld_c, corr_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({vld_a, vld_b, vld_c} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: valid=%b%b%b, required 000", i, vld_a, vld_b, vld_c);
            end
        end
        drive(1'b1, 32'h0000_0001, 0, 1);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 0, 0);
        checks++;
        if ({vld_a, dat_a} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL post_reset_accept: valid=%b data=%h, required 1 00000000", vld_a, dat_a);
        end
    endtask

    task automatic test_random();
        int          wdt  [3] = '{32, 16, 8};
        longint      cmax [3] = '{65535, 3, 65535};
        logic        mv;
        logic [31:0] m_data [3];
        int          m_stat [3];
        longint      m_corr [3];
        longint      m_unc  [3];
        logic        a_v [3];
        logic [31:0] a_d [3];
        logic [1:0]  a_s [3];
        logic [31:0] a_c [3];
        logic [31:0] a_u [3];
        logic        exp_rdy;
        logic        acc;
        logic [31:0] d;
        int          st;
        do_reset();
        mv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_data[k] = '0;
            m_stat[k] = 0;
            m_corr[k] = 0;
            m_unc[k]  = 0;
        end
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 3)));
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            #1;
            exp_rdy = !mv || out_ready;
            checks++;
            if ({rdy_a, rdy_b, rdy_c} !== {3{exp_rdy}}) begin
                errors++;
                $display("FAIL rand_ready iter %0d: in_ready=%b, required %b", i,
                         {rdy_a, rdy_b, rdy_c}, {3{exp_rdy}});
            end
            acc = in_valid && exp_rdy;
            for (int k = 0; k < 3; k++) begin
                ref_beat(wdt[k], codeword, int'(err_pos), int'(err_kind), d, st);
                if (acc) begin
                    m_data[k] = d;
                    m_stat[k] = st;
                end
                if (cnt_clr) begin
                    m_corr[k] = 0;
                    m_unc[k]  = 0;
                end else if (acc && st == 1) begin
                    m_corr[k] = (m_corr[k] < cmax[k]) ? m_corr[k] + 1 : cmax[k];
                end else if (acc && st == 2) begin
                    m_unc[k] = (m_unc[k] < cmax[k]) ? m_unc[k] + 1 : cmax[k];
                end
            end
            mv = acc || (mv && !out_ready);
            @(posedge clk);
            #1;
            a_v = '{vld_a, vld_b, vld_c};
            a_d = '{dat_a, 32'(dat_b), 32'(dat_c)};
            a_s = '{stat_a, stat_b, stat_c};
            a_c = '{32'(corr_a), 32'(corr_b), 32'(corr_c)};
            a_u = '{32'(uncorr_a), 32'(uncorr_b), 32'(uncorr_c)};
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (a_v[k] !== mv || (mv && {a_d[k], a_s[k]} !== {m_data[k], 2'(m_stat[k])})) begin
                    errors++;
                    $display("FAIL rand_beat w%0d iter %0d: valid=%b data=%h status=%b, required %b %h %0d",
                             wdt[k], i, a_v[k], a_d[k], a_s[k], mv, m_data[k], m_stat[k]);
                end
                checks++;
                if (a_c[k] !== m_corr[k][31:0] || a_u[k] !== m_unc[k][31:0]) begin
                    errors++;
                    $display("FAIL rand_count w%0d iter %0d: corr=%0d uncorr=%0d, required %0d %0d",
                             wdt[k], i, a_c[k], a_u[k], m_corr[k], m_unc[k]);
                end
            end
        end
        drive(1'b0, 32'h0, 0, 0);
        cnt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dec_correct_stage.md
Name: dec_correct_stage

Overview:
- Registered, handshaked single-bit correction stage for the decoder datapath.
- Accepts a codeword plus the error position and error class from the syndrome logic. Flips the indicated bit and emits corrected data with a status code.
- Generalises the fixed 8/16/32 combinational flipper: it supports any width, flags out-of-range positions instead of driving Z, applies valid/ready backpressure, and keeps saturating error statistics.

Parameters:
- DATA_WIDTH, 32, codeword/data width; any value 2..2**POS_W.
- POS_W, 5, width of the error-position index; must satisfy 2**POS_W >= DATA_WIDTH.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- codeword  in  DATA_WIDTH  received data bits.
- err_pos  in  POS_W  bit index to flip (0 = LSB).
- err_kind  in  2  00 none, 01 single, 10 double, 11 reserved.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- data_out  out  DATA_WIDTH  corrected data.
- out_status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 unused.
- corr_cnt  out  CNT_W  beats accepted with status 01.
- uncorr_cnt  out  CNT_W  beats accepted with status 10.
- cnt_clr  in  1  synchronous clear of both counters.

Behaviour:
- Reset (rst=0, async):
  - out_valid=0, data_out=0, out_status=00.
  - corr_cnt=0, uncorr_cnt=0.
  - in_ready is 1 as soon as rst is deasserted.
- Single pipeline register, with in_ready = !out_valid || out_ready (combinational from out_ready).
- Input accept condition: in_valid && in_ready. The accepted beat appears on the outputs next cycle (latency 1). Full throughput when out_ready is held at 1.
- Correction function, evaluated at accept:
  - err_kind=00: data_out=codeword, status 00.
  - err_kind=01 and err_pos<DATA_WIDTH: data_out=codeword with bit err_pos inverted; status 01.
  - err_kind=01 and err_pos>=DATA_WIDTH: data_out=codeword unchanged; status 10.
  - err_kind=10 or 11: data_out=codeword unchanged; status 10.
- Output hold: while out_valid=1 and out_ready=0, data_out and out_status are held stable and in_ready=0.
- Output retire: if out_valid=1 and out_ready=1 with no new accept, out_valid goes to 0 next cycle. data_out and out_status keep their last value (don't-care while out_valid=0).
- Simultaneous retire and accept: the register loads the new beat and out_valid stays 1.
- Counters increment on accept, not on retire. This makes them independent of backpressure.
- Counters saturate at 2**CNT_W-1 and never wrap.
- cnt_clr=1 in the same cycle as an accepted counted beat: the counter becomes 0, not 1. Clear has priority.
- Reset mid-transfer: the pending beat is discarded and counters are zeroed. No beat is emitted after rst deasserts until a new accept.
- There is no X/Z propagation from an undefined position. Every input combination yields a defined output.

Decomposition:
- Shared package dec_pkg:
  - typedef err_kind_t (ERR_NONE, ERR_SINGLE, ERR_DOUBLE, ERR_RSVD).
  - typedef dec_status_t (ST_CLEAN, ST_CORRECTED, ST_UNCORR).
- Sub-module dec_sat_counter (parameter CNT_W; inputs clk, rst, inc, clr; output cnt):
  - Saturating counter with clr priority.
  - Instantiated twice, once for corr_cnt and once for uncorr_cnt.
- The flip mask is generated inline as (1 << err_pos) gated by the range check. It needs no separate module.

Test Plan:
1. Reset, then DATA_WIDTH=32 beat codeword=0x0000_0000, err_kind=01, err_pos=5, out_ready=1 -> next cycle out_valid=1, data_out=0x0000_0020, out_status=01, corr_cnt=1.
2. DATA_WIDTH=16, err_kind=01, err_pos=20, codeword=0xBEEF -> data_out=0xBEEF, out_status=10, uncorr_cnt=1, corr_cnt=0.
3. Backpressure:
   - Stimulus: accept beat A (0x1234, none), then hold out_ready=0 for 3 cycles while in_valid=1 with beat B.
   - Response: in_ready=0 and data_out=0x1234 stable for 3 cycles. When out_ready=1, A retires and B loads in the same cycle; out_valid stays 1.
4. Streaming: 8 back-to-back beats with err_kind=01, err_pos=0..7 on DATA_WIDTH=8, codeword=0x00, out_ready=1 -> outputs 0x01,0x02,...,0x80 on consecutive cycles, corr_cnt=8.
5. CNT_W=2: 5 uncorrectable beats -> uncorr_cnt reads 1,2,3,3,3. Then cnt_clr=1 together with a 6th uncorrectable accept -> uncorr_cnt=0.
6. Assert rst=0 while out_valid=1 and out_ready=0 -> out_valid=0 and counters=0 immediately (async). After release, out_valid stays 0 until a new accept.
